// File: rtl/mode13h_pkg.sv
// Shared types and constants for the mode 13h (320x200, 256-colour) pixel path.
package mode13h_pkg;

    localparam int LOGICAL_WIDTH  = 320;
    localparam int LOGICAL_HEIGHT = 200;
    localparam int FB_BYTES       = 64000;

    typedef logic [7:0]  pal_index_t;
    typedef logic [15:0] fb_addr_t;

    // One palette entry: three 6-bit DAC fields, red in the MSBs.
    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
    } rgb666_t;

    // Per-pixel control bits that travel alongside the VRAM read.
    typedef struct packed {
        logic fetch;
        logic de;
        logic hsync;
        logic vsync;
    } pix_ctrl_t;

    // Linear framebuffer address y*320 + x, built from shifts so it maps onto adders.
    function automatic fb_addr_t fb_addr(input logic [8:0] x, input logic [7:0] y);
        fb_addr_t y_w;
        y_w = fb_addr_t'(y);
        return (y_w << 8) + (y_w << 6) + fb_addr_t'(x);
    endfunction

endpackage

// File: rtl/mode13h_palette_ram.sv
// 256 x 18-bit colour palette: one synchronous write port, one registered read port.
// A read and a write to the same entry on the same edge returns the old contents.
module mode13h_palette_ram
    import mode13h_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en_i,
    input  pal_index_t wr_index_i,
    input  rgb666_t    wr_data_i,
    input  pal_index_t rd_index_i,
    output rgb666_t    rd_data_o
);

    rgb666_t mem_q [256];
    rgb666_t rd_data_q;

    // Write the addressed entry and register the read; storage is loaded by software.
    // NOTE: the array has no reset branch -- a reset would stop it mapping onto block RAM,
    // and the non-blocking read below samples the entry before this edge's write lands,
    // which is exactly the read-before-write behaviour downstream relies on.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_index_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_index_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mode13h_pixel_pipeline.sv
// Mode 13h pixel back end: VRAM fetch, palette lookup and DAC output register,
// with display enable and syncs delayed to stay aligned with the colour data.
// Latency from inputs to vga_*/syncs/de_out is 3 + VRAM_LATENCY clocks.
module mode13h_pixel_pipeline
    import mode13h_pkg::*;
#(
    parameter int         VRAM_LATENCY = 1,
    parameter int         COLOR_BITS   = 4,
    parameter pal_index_t BORDER_INDEX = 8'd0,
    parameter logic       SYNC_IDLE    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8:0]            logical_x,
    input  logic [7:0]            logical_y,
    input  logic                  in_display_area,
    input  logic                  display_enable,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    output logic [15:0]           vram_addr,
    output logic                  vram_rd_en,
    input  logic [7:0]            vram_rd_data,
    input  logic                  pal_wr_en,
    input  logic [7:0]            pal_wr_index,
    input  logic [17:0]           pal_wr_data,
    output logic [COLOR_BITS-1:0] vga_r,
    output logic [COLOR_BITS-1:0] vga_g,
    output logic [COLOR_BITS-1:0] vga_b,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  de_out
);

    localparam pix_ctrl_t CTRL_RESET = '{fetch: 1'b0, de: 1'b0, hsync: SYNC_IDLE, vsync: SYNC_IDLE};

    // ---------------- Stage A: address generation ----------------
    logic      fetch_a;
    fb_addr_t  vram_addr_d;
    fb_addr_t  vram_addr_q;
    logic      vram_rd_en_q;
    pix_ctrl_t ctrl_a_q;

    // Out-of-window coordinates are treated as border even when the area flag is set.
    assign fetch_a = in_display_area
                  && (logical_x < 9'(LOGICAL_WIDTH))
                  && (logical_y < 8'(LOGICAL_HEIGHT));

    // The address only moves on a real fetch; otherwise it holds.
    assign vram_addr_d = fetch_a ? fb_addr(logical_x, logical_y) : vram_addr_q;

    // Register the read request together with the control bits of the same pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vram_addr_q  <= '0;
            vram_rd_en_q <= 1'b0;
            ctrl_a_q     <= CTRL_RESET;
        end else begin
            vram_addr_q  <= vram_addr_d;
            vram_rd_en_q <= fetch_a;
            ctrl_a_q     <= '{fetch: fetch_a, de: display_enable, hsync: hsync_in, vsync: vsync_in};
        end
    end

    // ---------------- Stage B: wait out the VRAM latency ----------------
    pix_ctrl_t ctrl_b_q [VRAM_LATENCY];
    pix_ctrl_t ctrl_b;

    // Shift the control bits so they emerge in the same cycle as vram_rd_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < VRAM_LATENCY; i++) begin
                ctrl_b_q[i] <= CTRL_RESET;
            end
        end else begin
            ctrl_b_q[0] <= ctrl_a_q;
            for (int i = 1; i < VRAM_LATENCY; i++) begin
                ctrl_b_q[i] <= ctrl_b_q[i-1];
            end
        end
    end

    assign ctrl_b = ctrl_b_q[VRAM_LATENCY-1];

    // ---------------- Stage C: palette read ----------------
    pal_index_t pal_rd_index;
    rgb666_t    pal_rd_data;
    logic       de_c_q;
    logic       hsync_c_q;
    logic       vsync_c_q;

    // Pick the VRAM index for fetched pixels and the border colour otherwise.
    // NOTE: the default assignment first means every path drives pal_rd_index,
    // so this stays pure combinational logic and never becomes a latch.
    always_comb begin
        pal_rd_index = BORDER_INDEX;
        if (ctrl_b.fetch) begin
            pal_rd_index = vram_rd_data;
        end
    end

    mode13h_palette_ram u_palette (
        .clk        (clk),
        .wr_en_i    (pal_wr_en),
        .wr_index_i (pal_wr_index),
        .wr_data_i  (rgb666_t'(pal_wr_data)),
        .rd_index_i (pal_rd_index),
        .rd_data_o  (pal_rd_data)
    );

    // Carry enable and syncs alongside the registered palette read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_c_q    <= 1'b0;
            hsync_c_q <= SYNC_IDLE;
            vsync_c_q <= SYNC_IDLE;
        end else begin
            de_c_q    <= ctrl_b.de;
            hsync_c_q <= ctrl_b.hsync;
            vsync_c_q <= ctrl_b.vsync;
        end
    end

    // ---------------- Stage D: DAC output register ----------------
    logic [COLOR_BITS-1:0] r_q;
    logic [COLOR_BITS-1:0] g_q;
    logic [COLOR_BITS-1:0] b_q;
    logic                  de_q;
    logic                  hsync_q;
    logic                  vsync_q;

    // Keep the top COLOR_BITS of each field during active video, force black in blanking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            de_q    <= 1'b0;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
        end else begin
            de_q    <= de_c_q;
            hsync_q <= hsync_c_q;
            vsync_q <= vsync_c_q;
            if (de_c_q) begin
                r_q <= COLOR_BITS'(pal_rd_data.r >> (6 - COLOR_BITS));
                g_q <= COLOR_BITS'(pal_rd_data.g >> (6 - COLOR_BITS));
                b_q <= COLOR_BITS'(pal_rd_data.b >> (6 - COLOR_BITS));
            end else begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end
        end
    end

    assign vram_addr  = vram_addr_q;
    assign vram_rd_en = vram_rd_en_q;
    assign vga_r      = r_q;
    assign vga_g      = g_q;
    assign vga_b      = b_q;
    assign de_out     = de_q;
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;

endmodule

// File: tb/tb_mode13h_pixel_pipeline.sv
// Scoreboard bench for mode13h_pixel_pipeline: one instance with VRAM_LATENCY=1
// (4-cycle latency) and one with VRAM_LATENCY=2 (5-cycle latency) share stimulus.
module tb_mode13h_pixel_pipeline;

    localparam int HALF = 5;

    typedef struct packed {
        logic        rst;
        logic        fetch;
        logic [15:0] addr;
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [8:0]  logical_x;
    logic [7:0]  logical_y;
    logic        in_display_area;
    logic        display_enable;
    logic        hsync_in;
    logic        vsync_in;
    logic        pal_wr_en;
    logic [7:0]  pal_wr_index;
    logic [17:0] pal_wr_data;

    logic [15:0] vram_addr   [2];
    logic        vram_rd_en  [2];
    logic [3:0]  vga_r       [2];
    logic [3:0]  vga_g       [2];
    logic [3:0]  vga_b       [2];
    logic        hsync_out   [2];
    logic        vsync_out   [2];
    logic        de_out      [2];

    logic [7:0]  vram_data_l1;
    logic [7:0]  vram_data_l2;
    logic [7:0]  vram_pipe_l2;

    logic [7:0]  vram_mem [65536];
    logic [17:0] pal_m    [256];
    logic [15:0] addr_m = '0;
    logic        rden_m = 1'b0;
    exp_t        sb_q     [2][$];

    int     n_checks = 0;
    int     n_fail   = 0;
    longint t0       = 0;
    longint fall_t [2] = '{-1, -1};
    longint rise_t [2] = '{-1, -1};
    logic   hs_prev [2] = '{1'b1, 1'b1};
    logic   meas_arm = 1'b0;

    mode13h_pixel_pipeline #(.VRAM_LATENCY(1)) u_dut_l1 (
        .clk (clk), .rst_n (rst_n),
        .logical_x (logical_x), .logical_y (logical_y),
        .in_display_area (in_display_area), .display_enable (display_enable),
        .hsync_in (hsync_in), .vsync_in (vsync_in),
        .vram_addr (vram_addr[0]), .vram_rd_en (vram_rd_en[0]), .vram_rd_data (vram_data_l1),
        .pal_wr_en (pal_wr_en), .pal_wr_index (pal_wr_index), .pal_wr_data (pal_wr_data),
        .vga_r (vga_r[0]), .vga_g (vga_g[0]), .vga_b (vga_b[0]),
        .hsync_out (hsync_out[0]), .vsync_out (vsync_out[0]), .de_out (de_out[0])
    );

    mode13h_pixel_pipeline #(.VRAM_LATENCY(2)) u_dut_l2 (
        .clk (clk), .rst_n (rst_n),
        .logical_x (logical_x), .logical_y (logical_y),
        .in_display_area (in_display_area), .display_enable (display_enable),
        .hsync_in (hsync_in), .vsync_in (vsync_in),
        .vram_addr (vram_addr[1]), .vram_rd_en (vram_rd_en[1]), .vram_rd_data (vram_data_l2),
        .pal_wr_en (pal_wr_en), .pal_wr_index (pal_wr_index), .pal_wr_data (pal_wr_data),
        .vga_r (vga_r[1]), .vga_g (vga_g[1]), .vga_b (vga_b[1]),
        .hsync_out (hsync_out[1]), .vsync_out (vsync_out[1]), .de_out (de_out[1])
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    // VRAM models: one and two cycles from address to data.
    always @(posedge clk) vram_data_l1 <= vram_mem[vram_addr[0]];
    always @(posedge clk) begin
        vram_pipe_l2 <= vram_mem[vram_addr[1]];
        vram_data_l2 <= vram_pipe_l2;
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        n_checks++;
        if (got !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, got, expected, $time);
        end
    endtask

    // Colour the pixel would show if its palette lookup happens now.
    function automatic logic [11:0] resolve(input exp_t e);
        logic [7:0]  pi;
        logic [17:0] c;
        pi = e.fetch ? vram_mem[e.addr] : 8'd0;
        c  = pal_m[pi];
        return e.de ? {c[17:14], c[11:8], c[5:2]} : 12'h000;
    endfunction

    // Push the pixel being sampled and colour the entry whose palette read is on this edge.
    task automatic sb_sample();
        exp_t e;
        exp_t r;
        int   k;
        e.rst   = ~rst_n;
        e.fetch = in_display_area && (logical_x < 9'd320) && (logical_y < 8'd200);
        e.addr  = 16'(int'(logical_y) * 320 + int'(logical_x));
        e.de    = display_enable;
        e.hs    = hsync_in;
        e.vs    = vsync_in;
        e.rgb   = 12'h000;
        for (int d = 0; d < 2; d++) begin
            sb_q[d].push_back(e);
            k = sb_q[d].size() - (lat_of(d) - 1);
            if (k >= 0) begin
                r = sb_q[d][k];
                r.rgb = resolve(r);
                sb_q[d][k] = r;
            end
        end
    endtask

    task automatic sb_pop(input int d);
        exp_t        e;
        logic        any_rst;
        logic [14:0] want;
        logic [14:0] got;
        any_rst = 1'b0;
        for (int i = 0; i < sb_q[d].size(); i++) any_rst |= sb_q[d][i].rst;
        e    = sb_q[d].pop_front();
        want = any_rst ? {12'h000, 1'b0, 1'b1, 1'b1} : {e.rgb, e.de, e.hs, e.vs};
        got  = {vga_r[d], vga_g[d], vga_b[d], de_out[d], hsync_out[d], vsync_out[d]};
        check(d == 0 ? "pix_l1" : "pix_l2", 32'(got), 32'(want));
    endtask

    always @(posedge clk) begin
        sb_sample();
        if (pal_wr_en) pal_m[pal_wr_index] <= pal_wr_data;
        if (!rst_n) begin
            addr_m <= '0;
            rden_m <= 1'b0;
        end else begin
            rden_m <= in_display_area && (logical_x < 9'd320) && (logical_y < 8'd200);
            if (in_display_area && (logical_x < 9'd320) && (logical_y < 8'd200))
                addr_m <= 16'(int'(logical_y) * 320 + int'(logical_x));
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check(d == 0 ? "addr_l1" : "addr_l2", 32'(vram_addr[d]), 32'(addr_m));
            check(d == 0 ? "rden_l1" : "rden_l2", 32'(vram_rd_en[d]), 32'(rden_m));
            if (sb_q[d].size() >= lat_of(d)) sb_pop(d);
        end
    end

    // Time the first hsync_out pulse after the sync test arms the monitor.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (meas_arm) begin
                if (fall_t[d] < 0 && hs_prev[d] && !hsync_out[d]) fall_t[d] <= $time;
                if (fall_t[d] >= 0 && rise_t[d] < 0 && !hs_prev[d] && hsync_out[d]) rise_t[d] <= $time;
            end
            hs_prev[d] <= hsync_out[d];
        end
    end

    task automatic px(input int x, input int y, input bit area, input bit de);
        @(negedge clk);
        logical_x       = 9'(x);
        logical_y       = 8'(y);
        in_display_area = area;
        display_enable  = de;
    endtask

    initial begin
        rst_n = 1'b0; logical_x = '0; logical_y = '0; in_display_area = 1'b0;
        display_enable = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        pal_wr_en = 1'b0; pal_wr_index = '0; pal_wr_data = '0;
        for (int i = 0; i < 65536; i++) vram_mem[i] = 8'(i * 37 + 11);
        vram_mem[3210] = 8'h2A;   // (10,10)
        vram_mem[9620] = 8'h05;   // (20,30)
        vram_mem[9621] = 8'h05;   // (21,30)

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_rgb",  32'({vga_r[d], vga_g[d], vga_b[d]}), 32'h0);
            check("rst_sync", 32'({hsync_out[d], vsync_out[d]}), 32'h3);
            check("rst_de",   32'(de_out[d]), 32'h0);
            check("rst_addr", 32'(vram_addr[d]), 32'h0);
            check("rst_rden", 32'(vram_rd_en[d]), 32'h0);
        end
        @(negedge clk); rst_n = 1'b1;

        // Load the whole palette during blanking
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pal_wr_en    = 1'b1;
            pal_wr_index = 8'(i);
            pal_wr_data  = (i == 8'h2A) ? 18'h3F000 : (i == 0) ? 18'h00FFF :
                           (i == 5) ? 18'h00000 : 18'($urandom);
        end
        @(negedge clk); pal_wr_en = 1'b0;

        // Address map corners
        px(0, 0, 1, 1);
        px(319, 0, 1, 1);   check("map_0_0",     32'(vram_addr[0]), 32'd0);
        px(0, 1, 1, 1);     check("map_319_0",   32'(vram_addr[0]), 32'd319);
        px(319, 199, 1, 1); check("map_0_1",     32'(vram_addr[0]), 32'd320);
        px(0, 0, 0, 0);     check("map_319_199", 32'(vram_addr[0]), 32'd63999);
                            check("map_rden",    32'(vram_rd_en[0]), 32'd1);
        repeat (6) px(0, 0, 0, 0);

        // Colour path: index 0x2A is pure red
        px(10, 10, 1, 1);
        px(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("red_rgb", 32'({vga_r[0], vga_g[0], vga_b[0]}), 32'hF00);
        check("red_de",  32'(de_out[0]), 32'd1);
        @(negedge clk);
        check("red_rgb_l2", 32'({vga_r[1], vga_g[1], vga_b[1]}), 32'hF00);

        // Border (area=0, and out of range with area=1) then blanking
        px(5, 5, 0, 1);
        px(320, 5, 1, 1);   check("brd_rden",  32'(vram_rd_en[0]), 32'd0);
        px(7, 7, 1, 0);     check("oor_rden",  32'(vram_rd_en[0]), 32'd0);
        px(0, 0, 0, 0);
        @(negedge clk);     check("brd_rgb",   32'({vga_r[0], vga_g[0], vga_b[0]}), 32'h0FF);
        @(negedge clk);     check("oor_rgb",   32'({vga_r[0], vga_g[0], vga_b[0]}), 32'h0FF);
        @(negedge clk);     check("blank_rgb", 32'({vga_r[0], vga_g[0], vga_b[0]}), 32'h000);
        repeat (4) px(0, 0, 0, 0);

        // Sync alignment: 96-cycle hsync pulse, short vsync pulse inside it
        meas_arm = 1'b1;
        px(0, 0, 0, 0); hsync_in = 1'b0; t0 = $time;
        for (int i = 0; i < 95; i++) begin
            px(0, 0, 0, 0);
            vsync_in = !(i >= 40 && i < 43);
        end
        px(0, 0, 0, 0); hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (10) px(0, 0, 0, 0);
        check("hs_off_l1",   32'(fall_t[0] - t0), 32'(8 * HALF));
        check("hs_off_l2",   32'(fall_t[1] - t0), 32'(10 * HALF));
        check("hs_width_l1", 32'(rise_t[0] - fall_t[0]), 32'(192 * HALF));
        check("hs_width_l2", 32'(rise_t[1] - fall_t[1]), 32'(192 * HALF));

        // Palette collision on entry 5
        px(20, 30, 1, 1);
        px(21, 30, 1, 1);
        px(0, 0, 0, 0); pal_wr_en = 1'b1; pal_wr_index = 8'd5; pal_wr_data = 18'h3FFFF;
        px(0, 0, 0, 0); pal_wr_en = 1'b0;
        @(negedge clk); check("coll_old", 32'({vga_r[0], vga_g[0], vga_b[0]}), 32'h000);
        @(negedge clk); check("coll_new", 32'({vga_r[0], vga_g[0], vga_b[0]}), 32'hFFF);
        repeat (4) px(0, 0, 0, 0);

        // Back-to-back random pixels, area toggling every cycle, sporadic palette writes
        for (int i = 0; i < 300; i++) begin
            px(int'($urandom_range(335, 0)), int'($urandom_range(207, 0)), i[0],
               $urandom_range(7, 0) != 0);
            hsync_in     = $urandom_range(15, 0) != 0;
            vsync_in     = $urandom_range(31, 0) != 0;
            pal_wr_en    = $urandom_range(9, 0) == 0;
            pal_wr_index = 8'($urandom);
            pal_wr_data  = 18'($urandom);
        end
        px(0, 0, 0, 0); pal_wr_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (6) px(0, 0, 0, 0);

        // Reset mid-line: two reset cycles inside an active run
        hsync_in = 1'b0; vsync_in = 1'b0;
        for (int i = 0; i < 6; i++) px(40 + i, 50, 1, 1);
        px(46, 50, 1, 1); rst_n = 1'b0;
        px(47, 50, 1, 1);
        check("mid_rst_rgb",  32'({vga_r[0], vga_g[0], vga_b[0]}), 32'h000);
        check("mid_rst_sync", 32'({hsync_out[0], vsync_out[0]}), 32'h3);
        check("mid_rst_de",   32'(de_out[0]), 32'd0);
        px(48, 50, 1, 1); rst_n = 1'b1;
        px(49, 50, 1, 1);
        px(50, 50, 1, 1);
        px(51, 50, 1, 1); check("flush_de",  32'(de_out[0]), 32'd0);
        px(52, 50, 1, 1); check("resume_de", 32'(de_out[0]), 32'd1);
        repeat (4) px(53, 50, 1, 1);
        hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (8) px(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mode13h_pixel_pipeline.md
Name: mode13h_pixel_pipeline

Overview:
Downstream consumer of the pixel-mapping stage. Takes logical 320x200 coordinates, the in-area flag and the raw VGA sync/enable signals. It fetches the 8-bit pixel index from framebuffer VRAM and resolves it through a 256-entry 18-bit (6:6:6) palette. It drives RGB to the DAC pins with hsync, vsync and display enable delayed to stay aligned with the colour data.

Parameters:
VRAM_LATENCY, 1, cycles from vram_addr/vram_rd_en to valid vram_rd_data (1..3).
COLOR_BITS, 4, bits per output colour channel (1..6); taken from the MSBs of each 6-bit palette field.
BORDER_INDEX, 0, palette index shown when display_enable=1 and in_display_area=0.
SYNC_IDLE, 1'b1, value driven on hsync_out/vsync_out during reset.

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
logical_x  in  9  logical x (0..319 valid)
logical_y  in  8  logical y (0..199 valid)
in_display_area  in  1  pixel lies inside the 320x200 window
display_enable  in  1  physical active video
hsync_in  in  1  raw hsync from timing controller
vsync_in  in  1  raw vsync from timing controller
vram_addr  out  16  framebuffer byte address
vram_rd_en  out  1  read strobe
vram_rd_data  in  8  pixel index, valid VRAM_LATENCY cycles after strobe
pal_wr_en  in  1  palette write strobe
pal_wr_index  in  8  palette entry to write
pal_wr_data  in  18  {r[5:0],g[5:0],b[5:0]}
vga_r  out  COLOR_BITS  red
vga_g  out  COLOR_BITS  green
vga_b  out  COLOR_BITS  blue
hsync_out  out  1  delayed hsync
vsync_out  out  1  delayed vsync
de_out  out  1  delayed display enable

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: vram_addr=0, vram_rd_en=0, vga_r/g/b=0, de_out=0, hsync_out=vsync_out=SYNC_IDLE. All delay-line valid/enable bits are cleared. Palette contents are NOT reset.
- Stage A (registered):
  - fetch = in_display_area && logical_x<320 && logical_y<200.
  - vram_addr = (y<<8)+(y<<6)+x, computed 16 bits wide; max 63999.
  - vram_rd_en = fetch.
  - When fetch=0, vram_addr holds its previous value.
  - Out-of-range coordinates with in_display_area=1 count as border and issue no read.
- Stage B (VRAM_LATENCY cycles): fetch, display_enable and both syncs travel through a matched shift register.
- Stage C (registered palette read):
  - index = fetch_d ? vram_rd_data : BORDER_INDEX.
- Stage D (output register):
  - de_d=1: RGB = palette MSBs.
  - de_d=0: RGB forced to 0 (blanking).
- Total latency: input to vga_*/hsync_out/vsync_out/de_out = 3+VRAM_LATENCY cycles (4 by default). The syncs are delayed by exactly the same count.
- Palette write:
  - Single cycle; takes effect on the next edge.
  - Simultaneous write and read of the same index: the read returns the OLD value (read-before-write). The new value is visible from the following cycle.
- Reset mid-frame: the pipeline flushes. Outputs hold reset values while rst_n=0. The first real pixel appears 3+VRAM_LATENCY cycles after the first input sampled with rst_n=1. In-flight reads are discarded.
- Back-to-back: one pixel per clock sustained, no stalls, no backpressure.
- in_display_area toggling every cycle: each pixel is resolved independently; no smear.

Decomposition:
- Package mode13h_pkg:
  - constants LOGICAL_WIDTH=320, LOGICAL_HEIGHT=200, FB_BYTES=64000
  - typedefs pal_index_t (8b), rgb666_t (struct r,g,b 6b), fb_addr_t (16b)
- Sub-module mode13h_palette_ram: 256x18, one synchronous write port, one registered read port with read-before-write semantics.
- The delay line stays inline.

Test Plan:
- Address map: (x,y) = (0,0), (319,0), (0,1), (319,199) with in_display_area=1 -> vram_addr 0, 319, 320, 63999 one cycle later, vram_rd_en=1.
- Colour path:
  - palette[0x2A]=18'h3F_000 (red 63, green 0, blue 0); VRAM model returns 0x2A.
  - -> vga_r=4'hF, vga_g=0, vga_b=0 exactly 4 cycles after the input, de_out=1.
- Border/blank:
  - palette[0]=18'h00FFF; display_enable=1, in_display_area=0 -> RGB = 0,F,F and vram_rd_en=0.
  - display_enable=0 -> RGB = 0,0,0.
- Sync alignment: pulse hsync_in low for 96 cycles -> hsync_out low for exactly 96 cycles, starting 4 cycles later. Repeat with VRAM_LATENCY=2 -> 5-cycle offset.
- Palette collision: write palette[5]=18'h3FFFF on the same cycle stage C reads index 5 (old value 0) -> that pixel outputs 0,0,0; the next pixel with index 5 outputs F,F,F.
- Reset mid-line:
  - Assert rst_n=0 for 2 cycles during active video.
  - -> outputs = 0, SYNC_IDLE, de_out=0 on the next edge.
  - -> valid pixels resume 4 cycles after release, with no stale data.
